seq_control_unit: RTL and testbench

- Registered, multi-cycle successor to the combinational opcode decoder in the tinyml RISC core.
- Accepts one instruction per valid/ready handshake and emits registered execute/writeback controls.
- Sequences multi-cycle ops, such as 3x3 convolution over CONV_TAPS steps, with a tap index, stall freeze and illegal-opcode flagging.
- Sits between instruction fetch and the ALU/regfile writeback mux.

---
 rtl/seq_control_unit_pkg.sv | 35 +++
 rtl/seq_control_unit_opcode_decoder.sv | 51 +++++
 rtl/seq_control_unit.sv | 133 +++++++++++++
 tb/tb_seq_control_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_control_unit_pkg.sv
// Shared opcode map, writeback selects and FSM encoding for the sequenced control unit.
package seq_control_unit_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LDI_LO = 4'h5;
  localparam logic [3:0] OP_LDI_HI = 4'h6;
  localparam logic [3:0] OP_ACC_RD = 4'h7;
  localparam logic [3:0] OP_MAC4   = 4'h8;
  localparam logic [3:0] OP_CONV   = 4'hD;
  localparam logic [3:0] OP_SIGM   = 4'hE;
  localparam logic [3:0] OP_ACC    = 4'hF;

  localparam logic [1:0] WB_ALU      = 2'd0;
  localparam logic [1:0] WB_IMM_LOW  = 2'd1;
  localparam logic [1:0] WB_IMM_HIGH = 2'd2;
  localparam logic [1:0] WB_ACC      = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CONV  = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src_imm;
    logic [1:0] writeback_sel;
    logic       acc_en;
    logic       is_conv;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/seq_control_unit_opcode_decoder.sv
// Pure combinational opcode -> control map; no state, zero latency, no flow control.
module seq_control_unit_opcode_decoder
  import seq_control_unit_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ENABLE_CONV = 1
) (
  input  logic [OPCODE_W-1:0] opcode,
  output dec_t                dec
);

  always_comb begin
    dec = '0;
    if (32'(opcode) > 32'd15) begin
      dec.is_illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MAC4, OP_SIGM: begin
          dec.reg_write     = 1'b1;
          dec.writeback_sel = WB_ALU;
        end
        OP_LDI_LO: begin
          dec.reg_write     = 1'b1;
          dec.alu_src_imm   = 1'b1;
          dec.writeback_sel = WB_IMM_LOW;
        end
        OP_LDI_HI: begin
          dec.reg_write     = 1'b1;
          dec.alu_src_imm   = 1'b1;
          dec.writeback_sel = WB_IMM_HIGH;
        end
        OP_ACC_RD: begin
          dec.reg_write     = 1'b1;
          dec.writeback_sel = WB_ACC;
        end
        OP_ACC: dec.acc_en = 1'b1;
        OP_CONV: begin
          if (ENABLE_CONV != 0) begin
            dec.is_conv       = 1'b1;
            dec.acc_en        = 1'b1;
            dec.writeback_sel = WB_ACC;
          end else begin
            dec.is_illegal = 1'b1;
          end
        end
        default: dec.is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/seq_control_unit.sv
// Registered control sequencer: accept at edge N, controls valid in cycle N+1; conv runs CONV_TAPS steps.
// stall freezes every register; instr_ready drops during stall and on non-final conv steps.
module seq_control_unit
  import seq_control_unit_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int CONV_TAPS   = 9,
  parameter int STEP_W      = 4,
  parameter int ENABLE_CONV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  output logic                reg_write,
  output logic                alu_src_imm,
  output logic [3:0]          alu_op,
  output logic [1:0]          writeback_sel,
  output logic                acc_en,
  output logic                acc_clr,
  output logic [STEP_W-1:0]   step_idx,
  output logic                busy,
  output logic                illegal
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CONV_TAPS - 1);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d, step_nxt;
  logic              reg_write_q, reg_write_d;
  logic              alu_src_imm_q, alu_src_imm_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic              acc_en_q, acc_en_d;
  logic              acc_clr_q, acc_clr_d;
  logic              illegal_q, illegal_d;
  logic              last_step, accept;
  dec_t              dec;

  seq_control_unit_opcode_decoder #(
    .OPCODE_W    (OPCODE_W),
    .ENABLE_CONV (ENABLE_CONV)
  ) u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  assign last_step   = (state_q == ST_CONV) && (step_q == LAST_STEP);
  assign instr_ready = !stall && ((state_q != ST_CONV) || last_step);
  assign accept      = instr_valid && instr_ready;
  assign step_nxt    = step_q + STEP_W'(1);

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    reg_write_d   = reg_write_q;
    alu_src_imm_d = alu_src_imm_q;
    alu_op_d      = alu_op_q;
    wb_sel_d      = wb_sel_q;
    acc_en_d      = acc_en_q;
    acc_clr_d     = acc_clr_q;
    illegal_d     = illegal_q;
    if (!stall) begin
      // Anything not re-armed below falls back to IDLE with all strobes low.
      state_d       = ST_IDLE;
      step_d        = '0;
      reg_write_d   = 1'b0;
      alu_src_imm_d = 1'b0;
      alu_op_d      = 4'd0;
      wb_sel_d      = WB_ALU;
      acc_en_d      = 1'b0;
      acc_clr_d     = 1'b0;
      illegal_d     = 1'b0;
      if (accept) begin
        alu_op_d = opcode[3:0];
        if (dec.is_illegal) begin
          illegal_d = 1'b1;
        end else begin
          state_d       = dec.is_conv ? ST_CONV : ST_ISSUE;
          reg_write_d   = dec.reg_write;
          alu_src_imm_d = dec.alu_src_imm;
          wb_sel_d      = dec.writeback_sel;
          acc_en_d      = dec.acc_en;
          acc_clr_d     = dec.is_conv;
        end
      end else if ((state_q == ST_CONV) && !last_step) begin
        state_d     = ST_CONV;
        step_d      = step_nxt;
        alu_op_d    = alu_op_q;
        acc_en_d    = 1'b1;
        wb_sel_d    = WB_ACC;
        reg_write_d = (step_nxt == LAST_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      reg_write_q   <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_op_q      <= 4'd0;
      wb_sel_q      <= WB_ALU;
      acc_en_q      <= 1'b0;
      acc_clr_q     <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      reg_write_q   <= reg_write_d;
      alu_src_imm_q <= alu_src_imm_d;
      alu_op_q      <= alu_op_d;
      wb_sel_q      <= wb_sel_d;
      acc_en_q      <= acc_en_d;
      acc_clr_q     <= acc_clr_d;
      illegal_q     <= illegal_d;
    end
  end

  assign reg_write     = reg_write_q;
  assign alu_src_imm   = alu_src_imm_q;
  assign alu_op        = alu_op_q;
  assign writeback_sel = wb_sel_q;
  assign acc_en        = acc_en_q;
  assign acc_clr       = acc_clr_q;
  assign step_idx      = step_q;
  assign busy          = (state_q == ST_CONV);
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench: default build, a conv-disabled build and a 2-tap build driven side by side.
module tb_seq_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: CONV_TAPS=9, STEP_W=4, ENABLE_CONV=1
  logic v0 = 0, st0 = 0, rdy0, rw0, imm0, ae0, ac0, busy0, ill0;
  logic [3:0] op0 = 0, alu0, si0;
  logic [1:0] wb0;
  // dut1: ENABLE_CONV=0
  logic v1 = 0, st1 = 0, rdy1, rw1, imm1, ae1, ac1, busy1, ill1;
  logic [3:0] op1 = 0, alu1, si1;
  logic [1:0] wb1;
  // dut2: CONV_TAPS=2, STEP_W=1
  logic v2 = 0, st2 = 0, rdy2, rw2, imm2, ae2, ac2, busy2, ill2;
  logic [3:0] op2 = 0, alu2;
  logic [0:0] si2;
  logic [1:0] wb2;

  seq_control_unit #(.OPCODE_W(4), .CONV_TAPS(9), .STEP_W(4), .ENABLE_CONV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v0), .instr_ready(rdy0), .opcode(op0), .stall(st0),
    .reg_write(rw0), .alu_src_imm(imm0), .alu_op(alu0), .writeback_sel(wb0), .acc_en(ae0),
    .acc_clr(ac0), .step_idx(si0), .busy(busy0), .illegal(ill0));

  seq_control_unit #(.OPCODE_W(4), .CONV_TAPS(9), .STEP_W(4), .ENABLE_CONV(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(rdy1), .opcode(op1), .stall(st1),
    .reg_write(rw1), .alu_src_imm(imm1), .alu_op(alu1), .writeback_sel(wb1), .acc_en(ae1),
    .acc_clr(ac1), .step_idx(si1), .busy(busy1), .illegal(ill1));

  seq_control_unit #(.OPCODE_W(4), .CONV_TAPS(2), .STEP_W(1), .ENABLE_CONV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v2), .instr_ready(rdy2), .opcode(op2), .stall(st2),
    .reg_write(rw2), .alu_src_imm(imm2), .alu_op(alu2), .writeback_sel(wb2), .acc_en(ae2),
    .acc_clr(ac2), .step_idx(si2), .busy(busy2), .illegal(ill2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet0(input string tag);
    chk({tag, "_rw"},   32'(rw0),   0);
    chk({tag, "_imm"},  32'(imm0),  0);
    chk({tag, "_alu"},  32'(alu0),  0);
    chk({tag, "_wb"},   32'(wb0),   0);
    chk({tag, "_ae"},   32'(ae0),   0);
    chk({tag, "_ac"},   32'(ac0),   0);
    chk({tag, "_step"}, 32'(si0),   0);
    chk({tag, "_busy"}, 32'(busy0), 0);
    chk({tag, "_ill"},  32'(ill0),  0);
    chk({tag, "_rdy"},  32'(rdy0),  1);
  endtask

  initial begin
    #3;
    chk_quiet0("rst");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Back-to-back single-cycle ops 0,5,6,F
    v0 = 1; op0 = 4'h0;
    tick();
    chk("b2b0_rw", 32'(rw0), 1);  chk("b2b0_wb", 32'(wb0), 0);
    chk("b2b0_imm", 32'(imm0), 0); chk("b2b0_rdy", 32'(rdy0), 1);
    op0 = 4'h5;
    tick();
    chk("b2b5_rw", 32'(rw0), 1);  chk("b2b5_wb", 32'(wb0), 1);
    chk("b2b5_imm", 32'(imm0), 1); chk("b2b5_alu", 32'(alu0), 5);
    op0 = 4'h6;
    tick();
    chk("b2b6_rw", 32'(rw0), 1);  chk("b2b6_wb", 32'(wb0), 2);
    chk("b2b6_imm", 32'(imm0), 1); chk("b2b6_rdy", 32'(rdy0), 1);
    op0 = 4'hF;
    tick();
    chk("b2bF_rw", 32'(rw0), 0);  chk("b2bF_ae", 32'(ae0), 1);
    chk("b2bF_alu", 32'(alu0), 15); chk("b2bF_busy", 32'(busy0), 0);
    v0 = 0;
    tick();
    chk_quiet0("idle");

    // Conv over 9 taps, opcode 0 accepted on the final step
    v0 = 1; op0 = 4'hD;
    tick();
    v0 = 0;
    chk("conv0_step", 32'(si0), 0); chk("conv0_busy", 32'(busy0), 1);
    chk("conv0_ac", 32'(ac0), 1);   chk("conv0_ae", 32'(ae0), 1);
    chk("conv0_rw", 32'(rw0), 0);   chk("conv0_rdy", 32'(rdy0), 0);
    for (int s = 1; s <= 8; s++) begin
      tick();
      chk($sformatf("conv%0d_step", s), 32'(si0), 32'(s));
      chk($sformatf("conv%0d_busy", s), 32'(busy0), 1);
      chk($sformatf("conv%0d_ac", s), 32'(ac0), 0);
      chk($sformatf("conv%0d_ae", s), 32'(ae0), 1);
      chk($sformatf("conv%0d_rw", s), 32'(rw0), (s == 8) ? 1 : 0);
      chk($sformatf("conv%0d_rdy", s), 32'(rdy0), (s == 8) ? 1 : 0);
    end
    chk("conv8_wb", 32'(wb0), 3);
    v0 = 1; op0 = 4'h0;
    tick();
    v0 = 0;
    chk("post_rw", 32'(rw0), 1);    chk("post_wb", 32'(wb0), 0);
    chk("post_busy", 32'(busy0), 0); chk("post_step", 32'(si0), 0);
    tick();
    chk("post2_rw", 32'(rw0), 0);

    // Stall at step 3 for two cycles
    v0 = 1; op0 = 4'hD;
    tick();
    v0 = 0;
    tick(); tick(); tick();
    chk("stl_pre_step", 32'(si0), 3);
    st0 = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("stl%0d_step", k), 32'(si0), 3);
      chk($sformatf("stl%0d_rdy", k), 32'(rdy0), 0);
      chk($sformatf("stl%0d_ae", k), 32'(ae0), 1);
    end
    st0 = 0;
    for (int k = 4; k <= 8; k++) begin
      tick();
      chk($sformatf("stlr%0d_step", k), 32'(si0), 32'(k));
      chk($sformatf("stlr%0d_rw", k), 32'(rw0), (k == 8) ? 1 : 0);
    end
    tick();
    chk("stl_end_busy", 32'(busy0), 0);

    // Async reset at conv step 4
    v0 = 1; op0 = 4'hD;
    tick();
    v0 = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("rc_step4", 32'(si0), 4);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet0("rc");
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rc_after%0d_rw", k), 32'(rw0), 0);
      chk($sformatf("rc_after%0d_busy", k), 32'(busy0), 0);
    end

    // Illegal opcodes on the conv-disabled build
    v1 = 1; op1 = 4'h9;
    tick();
    chk("ill9", 32'(ill1), 1); chk("ill9_rw", 32'(rw1), 0); chk("ill9_ae", 32'(ae1), 0);
    op1 = 4'hC;
    tick();
    chk("illC", 32'(ill1), 1); chk("illC_rw", 32'(rw1), 0); chk("illC_busy", 32'(busy1), 0);
    op1 = 4'hD;
    tick();
    v1 = 0;
    chk("illD", 32'(ill1), 1); chk("illD_ae", 32'(ae1), 0); chk("illD_busy", 32'(busy1), 0);
    tick();
    chk("ill_clear", 32'(ill1), 0);

    // 2-tap conv build
    v2 = 1; op2 = 4'hD;
    tick();
    v2 = 0;
    chk("t2_s0_step", 32'(si2), 0); chk("t2_s0_ac", 32'(ac2), 1);
    chk("t2_s0_rw", 32'(rw2), 0);   chk("t2_s0_busy", 32'(busy2), 1);
    tick();
    chk("t2_s1_step", 32'(si2), 1); chk("t2_s1_rw", 32'(rw2), 1);
    chk("t2_s1_wb", 32'(wb2), 3);   chk("t2_s1_ac", 32'(ac2), 0);
    tick();
    chk("t2_done_busy", 32'(busy2), 0); chk("t2_done_rw", 32'(rw2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
